// File: rtl/wb_int_ctrl.sv
// Wishbone-slave interrupt controller: per-source synchroniser, level/edge mode,
// mask, pending latch, software force and atomic claim, with registered INT/CAUSE.
module wb_int_ctrl #(
  parameter int N_SRC       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             STB,
  input  logic             WE,
  input  logic [31:0]      ADDR,
  input  logic [31:0]      DAT_I,
  output logic [31:0]      DAT_O,
  output logic             ACK,
  input  logic [N_SRC-1:0] irq_src,
  output logic             INT,
  output logic [31:0]      CAUSE
);

  localparam logic [2:0] REG_PENDING = 3'd0;
  localparam logic [2:0] REG_MASK    = 3'd1;
  localparam logic [2:0] REG_MODE    = 3'd2;
  localparam logic [2:0] REG_STATUS  = 3'd3;
  localparam logic [2:0] REG_FORCE   = 3'd4;
  localparam logic [2:0] REG_CLAIM   = 3'd5;

  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] sync_d [SYNC_STAGES];
  logic [N_SRC-1:0] s, s_d_q, s_d_d;
  logic [N_SRC-1:0] pending_q, pending_d, mask_q, mask_d, mode_q, mode_d;
  logic             ack_q, ack_d, int_q, int_d;
  logic [31:0]      dat_o_q, dat_o_d, cause_q, cause_d;

  logic             access, wr, rd, any;
  logic [2:0]       reg_sel;
  logic [4:0]       idx;
  logic [N_SRC-1:0] enabled, onehot, wdat, set_e, clr_e;
  logic [31:0]      status, rdata;

  assign s = sync_q[SYNC_STAGES-1];

  // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latches).
  always_comb begin
    access  = STB & ~ack_q;
    wr      = access & WE;
    rd      = access & ~WE;
    reg_sel = ADDR[4:2];
    wdat    = DAT_I[N_SRC-1:0];

    sync_d[0] = irq_src;
    for (int st = 1; st < SYNC_STAGES; st++) sync_d[st] = sync_q[st-1];
    s_d_d = s;

    // Descending scan so the lowest-index enabled source wins.
    enabled = pending_q & mask_q;
    any     = |enabled;
    idx     = '0;
    onehot  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (enabled[i]) begin
        idx       = 5'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
    status = {any, 26'b0, idx};

    // Edge-mode bits: any set event beats any clear event on the same edge.
    set_e = (s & ~s_d_q) | ((wr && reg_sel == REG_FORCE) ? wdat : '0);
    clr_e = ((wr && reg_sel == REG_PENDING) ? wdat : '0)
          | ((rd && reg_sel == REG_CLAIM && any) ? onehot : '0);
    pending_d = (mode_q & ((pending_q & ~clr_e) | set_e)) | (~mode_q & s);

    mask_d = (wr && reg_sel == REG_MASK) ? wdat : mask_q;
    mode_d = (wr && reg_sel == REG_MODE) ? wdat : mode_q;

    case (reg_sel)
      REG_PENDING: rdata = 32'(pending_q);
      REG_MASK:    rdata = 32'(mask_q);
      REG_MODE:    rdata = 32'(mode_q);
      REG_STATUS:  rdata = status;
      REG_CLAIM:   rdata = status;
      default:     rdata = '0;
    endcase

    ack_d   = access;
    dat_o_d = access ? rdata : dat_o_q;
    int_d   = any;
    cause_d = any ? 32'(idx) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the synchroniser array is a handful of flops, so it is reset like any other state.
      for (int st = 0; st < SYNC_STAGES; st++) sync_q[st] <= '0;
      s_d_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      mode_q    <= '0;
      ack_q     <= 1'b0;
      dat_o_q   <= '0;
      int_q     <= 1'b0;
      cause_q   <= '0;
    end else begin
      for (int st = 0; st < SYNC_STAGES; st++) sync_q[st] <= sync_d[st];
      s_d_q     <= s_d_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      ack_q     <= ack_d;
      dat_o_q   <= dat_o_d;
      int_q     <= int_d;
      cause_q   <= cause_d;
    end
  end

  assign ACK   = ack_q;
  assign DAT_O = dat_o_q;
  assign INT   = int_q;
  assign CAUSE = cause_q;

endmodule

// File: doc/wb_int_ctrl.md
Name: wb_int_ctrl

Overview:
- Parametrised Wishbone-slave interrupt controller with N_SRC sources.
- Replaces the hard-wired OR/priority chain that currently drives the CPU's INT and Cause_in inputs.
- Per source: synchronisation, level or rising-edge mode, mask, pending latch, software force and atomic claim.
- Outputs a registered INT and the index of the highest-priority (lowest-index) active source.

Parameters:
- N_SRC, 8, number of interrupt sources; legal range 1..31.
- SYNC_STAGES, 2, flip-flop stages on each irq_src bit; legal range 1..3.

Ports:
- clk  in  1  system clock; all logic rises on it.
- rst  in  1  asynchronous, active-high reset.
- STB  in  1  Wishbone strobe from intercon.
- WE  in  1  1 = write, 0 = read.
- ADDR  in  32  byte address; only ADDR[4:2] decoded.
- DAT_I  in  32  write data.
- DAT_O  out  32  registered read data.
- ACK  out  1  registered transfer acknowledge.
- irq_src  in  N_SRC  raw, asynchronous interrupt requests.
- INT  out  1  registered interrupt request to the CPU.
- CAUSE  out  32  registered index of the winning source; 0 when INT=0.

Behaviour:
- Reset (asynchronous, immediate on rst=1; applies mid-transaction too): ACK=0, DAT_O=0, INT=0, CAUSE=0. MASK=0, MODE=0 (all level), PENDING=0, all sync and edge flops 0.
- Handshake:
  - On an edge with STB=1 and ACK=0, the access executes; ACK=1 and DAT_O are loaded at that edge.
  - The next edge clears ACK.
  - A held STB therefore yields one access every 2 cycles.
  - DAT_O holds its value when ACK=0.
- Register map, index ADDR[4:2]. Only bits [N_SRC-1:0] exist; upper bits read 0.
  - 0 PENDING: R. W = write-1-to-clear, edge-mode bits only.
  - 1 MASK: RW. 1 = enabled.
  - 2 MODE: RW. 1 = rising-edge, 0 = level.
  - 3 STATUS: R = {INT_next, 26'b0, idx[4:0]}; idx = lowest i with PENDING[i]&MASK[i]; 0 if none. Writes ignored.
  - 4 FORCE: W-only; each 1 sets PENDING for edge-mode bits; level-mode bits ignored. Reads 0.
  - 5 CLAIM: R returns the STATUS value. At the same edge, clears PENDING[idx] if that source is edge-mode and the valid bit is 1. Writes ignored.
  - 6, 7: read 0, writes ignored; ACK still given.
- Synchroniser: irq_src[i] passes through SYNC_STAGES flops giving s[i]; s_d[i] is s[i] delayed one cycle.
- Level mode: PENDING[i] = s[i] every cycle. W1C, FORCE and CLAIM have no lasting effect.
- Edge mode: s[i]&~s_d[i] sets PENDING[i].
  - Precedence when events coincide on one edge: set (hardware edge or FORCE) beats clear (W1C or CLAIM). The bit stays 1.
  - Held-high input sets PENDING only once; it must go low then high again to re-arm.
- Switching MODE 1→0: PENDING follows s next cycle. Switching 0→1: PENDING keeps its current value until cleared.
- Output stage: INT and CAUSE are registered from PENDING & MASK. Latency: irq_src rising before edge k gives PENDING=1 at edge k+SYNC_STAGES, INT/CAUSE at edge k+SYNC_STAGES+1.
- CAUSE equals {27'b0, idx} when INT=1, else 0.
- Masking a pending source drops INT on the next edge, unless another enabled source is pending. PENDING itself is preserved.
- Priority is fixed: index 0 highest. No nesting or preemption state.

Test Plan:
- Reset, then read regs 0..7 -> all DAT_O=0, INT=0, CAUSE=0. Each access ACKs exactly one cycle after STB.
- MODE=0, MASK=8'h04, irq_src[2] pulsed high 1 cycle at edge k -> INT=1 and CAUSE=2 from edge k+3 for 1 cycle. Falling follows the same latency. PENDING reads track the input.
- MODE=8'hFF, MASK=8'hFF, raise src 5 then src 1 (held high) -> CAUSE=5, then CAUSE=1 once src 1 is pending. CLAIM returns 32'h8000_0001; next CLAIM returns 32'h8000_0005; third CLAIM returns 0 and INT=0.
- Edge mode, src 3 rising edge lands on the same edge as a W1C of bit 3 -> PENDING[3] stays 1.
- FORCE write 8'h81 with MODE=8'h80 and MASK=8'hFF -> PENDING=8'h80, CAUSE=7; bit 0 (level mode) is not set.
- Assert rst while STB=1 and PENDING=8'hFF -> all outputs and registers are 0 immediately. After release, the next STB gets a normal ACK.
